// File: rtl/dma_bench_pkg.sv
// Shared DMA benchmark definitions: engine status codes and {ch, req_tag} tag packing helpers.
// Engine-side and scheduler logic use the same helpers so tags are split identically on both sides.
package dma_bench_pkg;

    localparam logic [3:0] DMA_STATUS_ERR_NONE      = 4'h0;
    localparam logic [3:0] DMA_STATUS_ERR_TIMEOUT   = 4'h1;
    localparam logic [3:0] DMA_STATUS_ERR_PARITY    = 4'h2;
    localparam logic [3:0] DMA_STATUS_ERR_CPL_ABORT = 4'h3;
    localparam logic [3:0] DMA_STATUS_ERR_CPL_UR    = 4'h4;

    localparam int DMA_TAG_MAX_WIDTH = 32;

    // Engine tag = {ch, req_tag}; callers size-cast the 32-bit result to their tag width.
    function automatic logic [31:0] dma_tag_pack(input logic [31:0] ch,
                                                 input logic [31:0] req_tag,
                                                 input int          req_tag_width);
        return (ch << req_tag_width) | (req_tag & ((32'd1 << req_tag_width) - 32'd1));
    endfunction

    function automatic logic [31:0] dma_tag_ch(input logic [31:0] tag,
                                               input int          req_tag_width);
        return tag >> req_tag_width;
    endfunction

    function automatic logic [31:0] dma_tag_req(input logic [31:0] tag,
                                                input int          req_tag_width);
        return tag & ((32'd1 << req_tag_width) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the rotating pointer.
// Latency: combinational grant; pointer moves past the winner on the cycle accept is high.
// Backpressure: caller masks req when it cannot take a grant; no internal stall.
module rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 accept,
    output logic [WIDTH-1:0]     grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_vld
);

    logic [IDX_WIDTH-1:0] rr_ptr;
    int                   pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= WIDTH)
                pos = pos - WIDTH;
            if (!grant_vld && req[IDX_WIDTH'(pos)]) begin
                grant_vld                 = 1'b1;
                grant[IDX_WIDTH'(pos)]    = 1'b1;
                grant_idx                 = IDX_WIDTH'(pos);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && grant_vld) begin
            if (grant_idx == IDX_WIDTH'(WIDTH - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + IDX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dma_desc_sched.sv
// Round-robin descriptor scheduler sharing one DMA descriptor port among CH_COUNT requesters with per-channel in-flight limits.
// Latency: grant to m_axis_desc_valid 1 cycle; engine status to per-channel status 1 cycle; one descriptor per cycle sustained.
// Backpressure: s_axis_desc_ready only when the output register is free and the channel is below its limit; held descriptors are never withdrawn.
module dma_desc_sched
    import dma_bench_pkg::*;
#(
    parameter int CH_COUNT        = 4,
    parameter int CH_SEL_WIDTH    = $clog2(CH_COUNT),
    parameter int DMA_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int REQ_TAG_WIDTH   = 6,
    parameter int DMA_TAG_WIDTH   = REQ_TAG_WIDTH + CH_SEL_WIDTH,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [CH_COUNT*DMA_ADDR_WIDTH-1:0] s_axis_desc_dma_addr,
    input  logic [CH_COUNT*LEN_WIDTH-1:0]      s_axis_desc_len,
    input  logic [CH_COUNT*REQ_TAG_WIDTH-1:0]  s_axis_desc_tag,
    input  logic [CH_COUNT-1:0]                s_axis_desc_valid,
    output logic [CH_COUNT-1:0]                s_axis_desc_ready,
    output logic [DMA_ADDR_WIDTH-1:0]          m_axis_desc_dma_addr,
    output logic [LEN_WIDTH-1:0]               m_axis_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]           m_axis_desc_tag,
    output logic                               m_axis_desc_valid,
    input  logic                               m_axis_desc_ready,
    input  logic [DMA_TAG_WIDTH-1:0]           s_axis_desc_status_tag,
    input  logic [3:0]                         s_axis_desc_status_error,
    input  logic                               s_axis_desc_status_valid,
    output logic [CH_COUNT*REQ_TAG_WIDTH-1:0]  m_axis_desc_status_tag,
    output logic [CH_COUNT*4-1:0]              m_axis_desc_status_error,
    output logic [CH_COUNT-1:0]                m_axis_desc_status_valid,
    output logic [CH_COUNT*CNT_WIDTH-1:0]      stat_outstanding,
    output logic                               stat_status_err
);

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]      len;
        logic [REQ_TAG_WIDTH-1:0]  tag;
    } desc_t;

    logic                    active;
    logic [CNT_WIDTH-1:0]    count [CH_COUNT];
    logic                    out_free;
    logic [CH_COUNT-1:0]     req;
    logic [CH_COUNT-1:0]     grant;
    logic [CH_SEL_WIDTH-1:0] grant_idx;
    logic                    grant_vld;
    desc_t                   sel_desc;
    logic [31:0]             st_ch;
    logic [CH_COUNT-1:0]     dec;
    logic                    st_unmatched;

    // Keeps ready low while in reset and for the release edge, so every output is 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            active <= 1'b0;
        else
            active <= 1'b1;
    end

    assign out_free = !m_axis_desc_valid || m_axis_desc_ready;

    always_comb begin
        req = '0;
        for (int i = 0; i < CH_COUNT; i++)
            req[i] = active && enable && out_free && s_axis_desc_valid[i]
                     && (count[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end

    rr_arbiter #(
        .WIDTH     (CH_COUNT),
        .IDX_WIDTH (CH_SEL_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .accept    (grant_vld),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign s_axis_desc_ready = grant;

    always_comb begin
        sel_desc = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (grant[i]) begin
                sel_desc.addr = s_axis_desc_dma_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
                sel_desc.len  = s_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_desc.tag  = s_axis_desc_tag[i*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_desc_valid    <= 1'b0;
            m_axis_desc_dma_addr <= '0;
            m_axis_desc_len      <= '0;
            m_axis_desc_tag      <= '0;
        end else if (grant_vld) begin
            m_axis_desc_valid    <= 1'b1;
            m_axis_desc_dma_addr <= sel_desc.addr;
            m_axis_desc_len      <= sel_desc.len;
            m_axis_desc_tag      <= DMA_TAG_WIDTH'(dma_tag_pack(32'(grant_idx), 32'(sel_desc.tag), REQ_TAG_WIDTH));
        end else if (m_axis_desc_ready) begin
            m_axis_desc_valid    <= 1'b0;
        end
    end

    // A status only counts if it names a real channel that actually has work in flight.
    assign st_ch = dma_tag_ch(32'(s_axis_desc_status_tag), REQ_TAG_WIDTH);

    always_comb begin
        dec = '0;
        for (int i = 0; i < CH_COUNT; i++)
            dec[i] = s_axis_desc_status_valid && (st_ch == 32'(i)) && (count[i] != '0);
    end

    assign st_unmatched = s_axis_desc_status_valid && (dec == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_COUNT; i++)
                count[i] <= '0;
        end else begin
            for (int i = 0; i < CH_COUNT; i++) begin
                case ({grant[i], dec[i]})
                    2'b10:   count[i] <= count[i] + CNT_WIDTH'(1);
                    2'b01:   count[i] <= count[i] - CNT_WIDTH'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_desc_status_valid <= '0;
            m_axis_desc_status_tag   <= '0;
            m_axis_desc_status_error <= '0;
            stat_status_err          <= 1'b0;
        end else begin
            m_axis_desc_status_valid <= dec;
            stat_status_err          <= stat_status_err || st_unmatched;
            for (int i = 0; i < CH_COUNT; i++) begin
                if (dec[i]) begin
                    m_axis_desc_status_tag[i*REQ_TAG_WIDTH +: REQ_TAG_WIDTH] <=
                        REQ_TAG_WIDTH'(dma_tag_req(32'(s_axis_desc_status_tag), REQ_TAG_WIDTH));
                    m_axis_desc_status_error[i*4 +: 4] <= s_axis_desc_status_error;
                end
            end
        end
    end

    always_comb begin
        stat_outstanding = '0;
        for (int i = 0; i < CH_COUNT; i++)
            stat_outstanding[i*CNT_WIDTH +: CNT_WIDTH] = count[i];
    end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: scoreboard of granted descriptors plus per-scenario tasks.
`timescale 1ns/1ps
module tb_dma_desc_sched;
    import dma_bench_pkg::*;

    localparam int CH = 4, AW = 64, LW = 16, RW = 6, SW = 2, TW = 8, CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [CH*AW-1:0]  s_addr;
    logic [CH*LW-1:0]  s_len;
    logic [CH*RW-1:0]  s_tag;
    logic [CH-1:0]     s_valid = '0;
    logic [CH-1:0]     s_ready;
    logic [AW-1:0]     m_addr;
    logic [LW-1:0]     m_len;
    logic [TW-1:0]     m_tag;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [TW-1:0]     st_tag = '0;
    logic [3:0]        st_err = '0;
    logic              st_valid = 1'b0;
    logic [CH*RW-1:0]  ms_tag;
    logic [CH*4-1:0]   ms_err;
    logic [CH-1:0]     ms_valid;
    logic [CH*CW-1:0]  stat_out;
    logic              stat_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [TW-1:0] tag;
    } desc_t;

    desc_t         exp_q[$];
    int            gnt_log[$];
    int            gnt_cyc[$];
    int            seq[CH];
    logic [CH-1:0] adv = '0;
    int            cyc = 0;
    int            cmp_cnt = 0;
    int            err_cnt = 0;

    always #5 clk = ~clk;

    dma_desc_sched dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .enable                   (enable),
        .s_axis_desc_dma_addr     (s_addr),
        .s_axis_desc_len          (s_len),
        .s_axis_desc_tag          (s_tag),
        .s_axis_desc_valid        (s_valid),
        .s_axis_desc_ready        (s_ready),
        .m_axis_desc_dma_addr     (m_addr),
        .m_axis_desc_len          (m_len),
        .m_axis_desc_tag          (m_tag),
        .m_axis_desc_valid        (m_valid),
        .m_axis_desc_ready        (m_ready),
        .s_axis_desc_status_tag   (st_tag),
        .s_axis_desc_status_error (st_err),
        .s_axis_desc_status_valid (st_valid),
        .m_axis_desc_status_tag   (ms_tag),
        .m_axis_desc_status_error (ms_err),
        .m_axis_desc_status_valid (ms_valid),
        .stat_outstanding         (stat_out),
        .stat_status_err          (stat_err)
    );

    // Descriptor n of channel ch; the engine-side tag is {ch, n[5:0]}.
    function automatic desc_t make_desc(input int ch, input int n);
        desc_t d;
        d.addr = (64'(ch + 1) << 40) | (64'(n) << 12);
        d.len  = LW'(64 + 16 * n + ch);
        d.tag  = {SW'(ch), RW'(n)};
        return d;
    endfunction

    task automatic apply_inputs();
        desc_t d;
        for (int c = 0; c < CH; c++) begin
            d = make_desc(c, seq[c]);
            s_addr[c*AW +: AW] = d.addr;
            s_len[c*LW +: LW]  = d.len;
            s_tag[c*RW +: RW]  = d.tag[RW-1:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < CH; c++)
            if (adv[c]) seq[c]++;
        adv = '0;
        apply_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; s_valid = '0; m_ready = 1'b0;
        st_valid = 1'b0; st_tag = '0; st_err = '0;
        for (int c = 0; c < CH; c++) seq[c] = 0;
        adv = '0;
        exp_q.delete(); gnt_log.delete(); gnt_cyc.delete();
        apply_inputs();
        #12;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard: grants push the bench's own descriptor, engine handshakes pop and compare.
    always @(negedge clk) begin
        desc_t e;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                cmp_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL sb_unexpected: got desc tag %h, required none pending", m_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_addr, m_len, m_tag} !== e) begin
                        err_cnt++;
                        $display("FAIL sb_desc: got %h/%h/%h, required %h/%h/%h",
                                 m_addr, m_len, m_tag, e.addr, e.len, e.tag);
                    end
                end
            end
            if (s_ready != '0) begin
                cmp_cnt++;
                if (!$onehot(s_ready)) begin
                    err_cnt++;
                    $display("FAIL ready_onehot: got %b, required one-hot", s_ready);
                end
                for (int c = 0; c < CH; c++) begin
                    if (s_ready[c]) begin
                        exp_q.push_back(make_desc(c, seq[c]));
                        gnt_log.push_back(c);
                        gnt_cyc.push_back(cyc);
                        adv[c] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; s_valid = '1; m_ready = 1'b1;
        apply_inputs();
        #13;
        cmp_cnt++; if (s_ready !== '0)  begin err_cnt++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        cmp_cnt++; if (stat_out !== '0)  begin err_cnt++; $display("FAIL rst_stat_out: got %h, required 0", stat_out); end
        cmp_cnt++; if (stat_err !== 1'b0) begin err_cnt++; $display("FAIL rst_stat_err: got %b, required 0", stat_err); end
        cmp_cnt++; if (ms_valid !== '0)  begin err_cnt++; $display("FAIL rst_ms_valid: got %b, required 0", ms_valid); end
        do_reset();
        repeat (2) tick();
        cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_m_valid: got %b, required 0", m_valid); end
        cmp_cnt++; if (stat_out !== '0)  begin err_cnt++; $display("FAIL idle_stat_out: got %h, required 0", stat_out); end
    endtask

    task automatic test_round_robin_fill();
        do_reset();
        enable = 1'b1; m_ready = 1'b1; s_valid = '1;
        repeat (40) tick();
        cmp_cnt++;
        if (gnt_log.size() !== 32) begin
            err_cnt++; $display("FAIL fill_grants: got %0d, required 32", gnt_log.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                cmp_cnt++;
                if (gnt_log[k] !== k % 4) begin
                    err_cnt++; $display("FAIL fill_order[%0d]: got ch %0d, required ch %0d", k, gnt_log[k], k % 4);
                end
            end
            cmp_cnt++;
            if (gnt_cyc[31] - gnt_cyc[0] !== 31) begin
                err_cnt++; $display("FAIL fill_rate: got span %0d, required 31", gnt_cyc[31] - gnt_cyc[0]);
            end
        end
        cmp_cnt++; if (stat_out !== 16'h8888) begin err_cnt++; $display("FAIL fill_stat_out: got %h, required 8888", stat_out); end
        cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL fill_drain: got %0d pending, required 0", exp_q.size()); end
        @(negedge clk);
        cmp_cnt++; if (s_ready !== '0) begin err_cnt++; $display("FAIL fill_limit: got ready %b, required 0", s_ready); end
    endtask

    task automatic test_status_regrant();
        int n0;
        n0 = gnt_log.size();
        st_tag = {2'd2, 6'd5}; st_err = DMA_STATUS_ERR_CPL_ABORT; st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        cmp_cnt++; if (ms_valid !== 4'b0100) begin err_cnt++; $display("FAIL st_pulse: got %b, required 0100", ms_valid); end
        cmp_cnt++; if (ms_tag[2*RW +: RW] !== 6'd5) begin err_cnt++; $display("FAIL st_tag: got %0d, required 5", ms_tag[2*RW +: RW]); end
        cmp_cnt++; if (ms_err[2*4 +: 4] !== DMA_STATUS_ERR_CPL_ABORT) begin err_cnt++; $display("FAIL st_err: got %h, required 3", ms_err[2*4 +: 4]); end
        cmp_cnt++; if (stat_out[2*CW +: CW] !== 4'd7) begin err_cnt++; $display("FAIL st_dec: got %0d, required 7", stat_out[2*CW +: CW]); end
        cmp_cnt++; if (s_ready !== 4'b0100) begin err_cnt++; $display("FAIL st_regrant: got %b, required 0100", s_ready); end
        tick();
        @(negedge clk);
        cmp_cnt++; if (ms_valid !== '0) begin err_cnt++; $display("FAIL st_one_pulse: got %b, required 0", ms_valid); end
        cmp_cnt++; if (stat_out !== 16'h8888) begin err_cnt++; $display("FAIL st_refill: got %h, required 8888", stat_out); end
        cmp_cnt++; if (s_ready !== '0) begin err_cnt++; $display("FAIL st_no_extra: got %b, required 0", s_ready); end
        cmp_cnt++;
        if (gnt_log.size() !== n0 + 1 || gnt_log[gnt_log.size()-1] !== 2) begin
            err_cnt++; $display("FAIL st_regrant_ch: got %0d grants, required %0d ending in ch 2", gnt_log.size(), n0 + 1);
        end
        repeat (3) tick();
        cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL st_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1; m_ready = 1'b0; s_valid = '1;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (exp_q.size() !== 1 || m_valid !== 1'b1 || {m_addr, m_len, m_tag} !== exp_q[0]) begin
                err_cnt++; $display("FAIL bp_hold[%0d]: got valid %b tag %h, required held ch0 desc", k, m_valid, m_tag);
            end
            cmp_cnt++; if (s_ready !== '0) begin err_cnt++; $display("FAIL bp_ready[%0d]: got %b, required 0", k, s_ready); end
            cmp_cnt++; if (stat_out !== 16'h0001) begin err_cnt++; $display("FAIL bp_count[%0d]: got %h, required 0001", k, stat_out); end
            tick();
        end
        m_ready = 1'b1; s_valid = '0;
        tick();
        cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL bp_accept: got %0d pending, required 0", exp_q.size()); end
        cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_empty: got %b, required 0", m_valid); end
        cmp_cnt++; if (gnt_log.size() !== 1) begin err_cnt++; $display("FAIL bp_grants: got %0d, required 1", gnt_log.size()); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        enable = 1'b1; m_ready = 1'b1; s_valid = 4'b0010;
        repeat (3) tick();
        s_valid = '0;
        cmp_cnt++; if (stat_out !== 16'h0030) begin err_cnt++; $display("FAIL sc_pre: got %h, required 0030", stat_out); end
        cmp_cnt++;
        if (gnt_cyc.size() !== 3 || gnt_cyc[2] - gnt_cyc[0] !== 2) begin
            err_cnt++; $display("FAIL sc_b2b: got %0d grants, required 3 on consecutive cycles", gnt_cyc.size());
        end
        s_valid = 4'b0010; st_tag = {2'd1, 6'd1}; st_err = DMA_STATUS_ERR_NONE; st_valid = 1'b1;
        @(negedge clk);
        cmp_cnt++; if (s_ready !== 4'b0010) begin err_cnt++; $display("FAIL sc_grant: got %b, required 0010", s_ready); end
        tick();
        s_valid = '0; st_valid = 1'b0;
        cmp_cnt++; if (stat_out !== 16'h0030) begin err_cnt++; $display("FAIL sc_net: got %h, required 0030", stat_out); end
        cmp_cnt++; if (ms_valid !== 4'b0010) begin err_cnt++; $display("FAIL sc_pulse: got %b, required 0010", ms_valid); end
        cmp_cnt++; if (gnt_log.size() !== 4) begin err_cnt++; $display("FAIL sc_grants: got %0d, required 4", gnt_log.size()); end
    endtask

    task automatic test_unmatched_status();
        st_tag = {2'd3, 6'd9}; st_err = DMA_STATUS_ERR_PARITY; st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
        cmp_cnt++; if (ms_valid !== '0) begin err_cnt++; $display("FAIL um_pulse: got %b, required 0", ms_valid); end
        cmp_cnt++; if (stat_err !== 1'b1) begin err_cnt++; $display("FAIL um_flag: got %b, required 1", stat_err); end
        cmp_cnt++; if (stat_out !== 16'h0030) begin err_cnt++; $display("FAIL um_counts: got %h, required 0030", stat_out); end
        repeat (3) tick();
        cmp_cnt++; if (stat_err !== 1'b1) begin err_cnt++; $display("FAIL um_sticky: got %b, required 1", stat_err); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1; m_ready = 1'b0; s_valid = 4'b0001;
        tick();
        enable = 1'b0; s_valid = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (m_valid !== 1'b1 || s_ready !== '0) begin
                err_cnt++; $display("FAIL en_hold[%0d]: got valid %b ready %b, required 1/0", k, m_valid, s_ready);
            end
            tick();
        end
        m_ready = 1'b1;
        tick();
        cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL en_accept: got %0d pending, required 0", exp_q.size()); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (m_valid !== 1'b0 || s_ready !== '0) begin
                err_cnt++; $display("FAIL en_no_grant[%0d]: got valid %b ready %b, required 0/0", k, m_valid, s_ready);
            end
            tick();
        end
        cmp_cnt++; if (stat_out !== 16'h0001) begin err_cnt++; $display("FAIL en_count: got %h, required 0001", stat_out); end
        enable = 1'b1; m_ready = 1'b0; st_tag = {2'd3, 6'd0}; st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
        tick();
        cmp_cnt++;
        if (m_valid !== 1'b1 || stat_err !== 1'b1) begin
            err_cnt++; $display("FAIL en_pre_rst: got valid %b err %b, required 1/1", m_valid, stat_err);
        end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_m_valid: got %b, required 0", m_valid); end
        cmp_cnt++; if (stat_out !== '0) begin err_cnt++; $display("FAIL arst_counts: got %h, required 0", stat_out); end
        cmp_cnt++; if (stat_err !== 1'b0) begin err_cnt++; $display("FAIL arst_err: got %b, required 0", stat_err); end
        cmp_cnt++; if (s_ready !== '0) begin err_cnt++; $display("FAIL arst_ready: got %b, required 0", s_ready); end
        cmp_cnt++; if (m_tag !== '0 || m_addr !== '0) begin err_cnt++; $display("FAIL arst_desc: got %h/%h, required 0", m_addr, m_tag); end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) seq[c] = 0;
        apply_inputs();
        test_reset();
        test_round_robin_fill();
        test_status_regrant();
        test_backpressure();
        test_same_cycle();
        test_unmatched_status();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200us");
        $fatal(1);
    end

endmodule
